// File: rtl/wr_sel_decoder_if.sv
// Write-select bus between the write-back stage and the register-file decoder.
// Handshake: there is no valid/ready pair on this bus. The master presents
// en/addr/sweep_start every cycle; the decoder samples them only while idle
// and reports sweep progress through sweep_busy and sweep_done.
interface wr_sel_decoder_if #(
    parameter int ADDR_W = 3
);
    localparam int OUT_W = 2 ** ADDR_W;

    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              sweep_start;
    logic [OUT_W-1:0]  y;
    logic              sweep_busy;
    logic              sweep_done;

    modport master (
        output en,
        output addr,
        output sweep_start,
        input  y,
        input  sweep_busy,
        input  sweep_done
    );

    modport slave (
        input  en,
        input  addr,
        input  sweep_start,
        output y,
        output sweep_busy,
        output sweep_done
    );
endinterface

// File: rtl/wr_sel_decoder.sv
// Registered address-to-one-hot write-enable decoder with a clear sweep.
// In IDLE it decodes en/addr; on sweep_start it walks every write-enable line
// once so the register file can be cleared without the datapath supplying
// addresses. Bit 0 can be masked off for a hardwired zero register.
module wr_sel_decoder #(
    parameter int ADDR_W    = 3,
    parameter bit MASK_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    wr_sel_decoder_if.slave   bus,
    output logic [1:0]        o_dbg_state
);
    localparam int OUT_W = 2 ** ADDR_W;
    // First index visited by a sweep; skips the hardwired zero register.
    localparam logic [ADDR_W-1:0] FIRST = MASK_ZERO ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [OUT_W-1:0]  r_y;
    logic              r_busy;
    logic              r_done;

    state_t            w_state;
    logic [ADDR_W-1:0] w_idx;
    logic [OUT_W-1:0]  w_y;
    logic              w_busy;
    logic              w_done;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_y     = '0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sweep_start) begin
                    // A sweep request takes precedence over a normal decode.
                    w_state = SWEEP;
                    w_idx   = FIRST;
                    w_busy  = 1'b1;
                end else if (bus.en && !(MASK_ZERO && (bus.addr == '0))) begin
                    w_y = OUT_W'(1) << bus.addr;
                end
            end
            SWEEP: begin
                w_y    = OUT_W'(1) << r_idx;
                w_busy = 1'b1;
                // Stop at the top index; the counter never wraps.
                if (r_idx == LAST) begin
                    w_state = DONE;
                end else begin
                    w_idx = r_idx + ADDR_W'(1);
                end
            end
            DONE: begin
                w_done  = 1'b1;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
                w_idx   = '0;
            end
        endcase
    end

    // State and output registers with synchronous, highest-priority reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_y     <= w_y;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign bus.y          = r_y;
    assign bus.sweep_busy = r_busy;
    assign bus.sweep_done = r_done;
    assign o_dbg_state    = r_state;
endmodule

// File: doc/wr_sel_decoder.md
# wr_sel_decoder

Parametrised, registered address-to-one-hot decoder driving register-file write-enable lines, generalising the fixed 3-to-8 enabled decoder. Besides normal decode it has a sweep mode: an internal sequencer asserts every output once in turn, so the register file can be cleared after reset without the datapath sourcing addresses. It sits between the write-back address/enable and the register-file bank.

## Interface
- ADDR_W, 3, address width; output width OUT_W = 2**ADDR_W (derived, not overridable)
- MASK_ZERO, 0, 1 = output bit 0 is never asserted (hardwired zero register), in decode and sweep
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset; synchronous and active-high
- en  in  1  decode enable; sampled only in IDLE
- addr  in  ADDR_W  register index to decode
- sweep_start  in  1  request a full sweep; sampled only in IDLE
- y  out  OUT_W  registered one-hot (or zero) write-enable vector
- sweep_busy  out  1  registered; high while a sweep is in progress
- sweep_done  out  1  registered; one-cycle pulse when a sweep completes

## Operation
- States: IDLE, SWEEP, DONE. Internal index counter idx, ADDR_W bits.
- IDLE, sweep_start=0: each edge y <= en ? (1 << addr) : 0; if MASK_ZERO=1 and addr=0, y <= 0.
- IDLE, sweep_start=1: sweep wins over en/addr. State <= SWEEP, idx <= FIRST (FIRST = MASK_ZERO ? 1 : 0), y <= 0, sweep_busy <= 1.
- SWEEP: each edge y <= 1 << idx; en, addr and sweep_start ignored. If idx = OUT_W-1, state <= DONE; else idx <= idx+1. No wrap-around: idx never passes OUT_W-1.
- DONE (one cycle): y <= 0, sweep_busy <= 0, sweep_done <= 1, state <= IDLE.
- Returning to IDLE: sweep_done <= 0 at the next edge; normal decode resumes at that same edge.
- sweep_start held high through a sweep and into IDLE starts a new sweep (level-sampled in IDLE); no queuing of requests made while busy.
- y is never multi-hot; at most one bit set in any cycle.

## Timing
- Reset (synchronous, any state including mid-sweep): state <= IDLE, idx <= 0, y <= 0, sweep_busy <= 0, sweep_done <= 0. rst has priority over all inputs.
- Decode latency: 1 cycle (inputs at edge k visible on y after edge k).
- Sweep, with request sampled at edge E0:
  - After E0: sweep_busy=1, y=0.
  - After E1 .. E(OUT_W-FIRST): y = onehot(FIRST) .. onehot(OUT_W-1).
  - After the next edge: y=0, sweep_busy=0, sweep_done=1.
- sweep_busy high for OUT_W-FIRST+1 cycles; total request-to-done = OUT_W-FIRST+2 edges.
- ADDR_W=1 valid: OUT_W=2; with MASK_ZERO=1 the sweep asserts only bit 1.

## Test plan
- Reset, then ADDR_W=3, MASK_ZERO=0, en=1, addr 0..7 one per cycle -> y = 0x01, 0x02 … 0x80, each one cycle after its addr; en=0 with any addr -> y=0x00.
- MASK_ZERO=1, en=1, addr=0 -> y=0x00; addr=5 -> y=0x20.
- ADDR_W=3, MASK_ZERO=0, one-cycle sweep_start -> busy=1 with y=0x00, then y = 0x01, 0x02 … 0x80 on 8 consecutive cycles (busy=1 for 9 cycles), then y=0x00, busy=0, done=1 for exactly one cycle; en=1/addr=3 applied throughout has no effect until done deasserts.
- MASK_ZERO=1 sweep -> y steps 0x02 … 0x80 (7 cycles), busy=1 for 8 cycles, then done pulse.
- sweep_start and en=1/addr=2 in the same IDLE cycle -> y=0x00 and busy=1 (sweep wins); sweep_start pulsed again mid-sweep -> ignored, exactly one done pulse.
- rst asserted while y=0x10 mid-sweep -> after that edge y=0x00, busy=0, done=0, state IDLE; the next en=1/addr=6 -> y=0x40 one cycle later.
